// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT
   } state_e;

   // 32 MHz clock, 115200 baud, 10-bit frame
   localparam int unsigned DEF_BYTE_CYCLES = 2778;
   localparam int unsigned MAX_NREQ        = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping at NREQ.
module rr_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   output logic [2:0]      idx,
   output logic            found
);

   logic [NREQ-1:0] pick_oh;

   always_comb begin
      int unsigned pos;
      pick_oh = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && (pos == j) && req[j]) begin
               found      = 1'b1;
               idx        = 3'(j);
               pick_oh[j] = 1'b1;
            end
         end
      end
   end

   logic pick_unused;
   assign pick_unused = ^pick_oh ^ (NREQ > MAX_NREQ);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte sources, paced one frame per byte.
// Define UART_ARB_LOCK_EN to let a requester keep the grant across frames via req_lock.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned BYTE_CYCLES = DEF_BYTE_CYCLES
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_lock,
   output logic [NREQ-1:0]   req_ack,
   output logic [7:0]        txdata,
   output logic              tx_enable,
   output logic [2:0]        grant_id,
   output logic              busy
);

   localparam int unsigned     CW       = $clog2(BYTE_CYCLES);
   // SEND + (CNT_LOAD+1) WAIT cycles + decision cycle in IDLE = BYTE_CYCLES
   localparam logic [CW-1:0]   CNT_LOAD = CW'(BYTE_CYCLES - 3);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [2:0]      grant_q, grant_d;
   logic [7:0]      txdata_q, txdata_d;

   logic [2:0]      rr_idx;
   logic            rr_found;
   logic            grant_en;
   logic [2:0]      win;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .idx   (rr_idx),
      .found (rr_found)
   );

`ifdef UART_ARB_LOCK_EN
   logic lock_q, lock_d;
   logic cur_valid, cur_lock;

   always_comb begin
      cur_valid = 1'b0;
      cur_lock  = 1'b0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (grant_q == 3'(j)) begin
            cur_valid = req_valid[j];
            cur_lock  = req_lock[j];
         end
      end
   end

   always_comb begin
      lock_d = lock_q;
      if (state_q == ST_WAIT && cnt_q == '0) lock_d = cur_lock;
   end

   always_ff @(posedge clk) begin
      if (!reset_) lock_q <= 1'b0;
      else         lock_q <= lock_d;
   end

   // A held lock grants only its owner, even if that means granting nothing
   always_comb begin
      if (lock_q && cur_lock) begin
         grant_en = cur_valid;
         win      = grant_q;
      end else begin
         grant_en = rr_found;
         win      = rr_idx;
      end
   end
`else
   logic lock_unused;
   assign lock_unused = ^req_lock;
   assign grant_en    = rr_found;
   assign win         = rr_idx;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      txdata_d = txdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_en) begin
               state_d = ST_SEND;
               grant_d = win;
               ptr_d   = (win == 3'(NREQ - 1)) ? '0 : win + 3'd1;
               for (int unsigned j = 0; j < NREQ; j++) begin
                  if (win == 3'(j)) txdata_d = req_data[8*j +: 8];
               end
            end
         end
         ST_SEND: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ptr_q    <= '0;
         grant_q  <= '0;
         txdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         txdata_q <= txdata_d;
      end
   end

   always_comb begin
      req_ack = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         req_ack[j] = (state_q == ST_SEND) && (grant_q == 3'(j));
      end
   end

   assign tx_enable = (state_q == ST_SEND);
   assign busy      = (state_q != ST_IDLE);
   assign txdata    = txdata_q;
   assign grant_id  = grant_q;

endmodule
